// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_dump_reader: walks registers FIRST_REG..LAST_REG two at a time      |
// | and streams each one out over valid/ready.    Rev 1.0                       |
// +----------------------------------------------------------------------------+
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter bit ZERO_X0   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr1,
  output logic [4:0]  rd_addr2,
  input  logic [31:0] rd_data1,
  input  logic [31:0] rd_data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data,
  output logic        out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] c_first = 6'(FIRST_REG);
  localparam logic [6:0] c_last  = 7'(LAST_REG);

  state_t      r_state;
  logic [5:0]  r_ptr;
  logic [1:0]  r_count;
  logic [4:0]  r_buf_index;
  logic [31:0] r_buf_data;
  logic        r_buf_last;

  logic [6:0]  w_ptr_p1;
  logic        w_pair;
  logic        w_beat;
  logic [31:0] w_data0;

  // Pointer is one bit wider than an index so stepping past 31 cannot wrap.
  assign w_ptr_p1 = {1'b0, r_ptr} + 7'd1;
  assign w_pair   = (w_ptr_p1 <= c_last);
  assign rd_addr1 = r_ptr[4:0];
  assign rd_addr2 = w_pair ? w_ptr_p1[4:0] : r_ptr[4:0];
  assign w_data0  = (ZERO_X0 && (r_ptr == 6'd0)) ? 32'h0 : rd_data1;
  assign w_beat   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= c_first;
      r_count     <= 2'd0;
      r_buf_index <= 5'd0;
      r_buf_data  <= 32'h0;
      r_buf_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_index   <= 5'd0;
      out_data    <= 32'h0;
      out_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          // Entry 0 goes straight to the output register; entry 1 waits in the buffer.
          out_valid   <= 1'b1;
          out_index   <= r_ptr[4:0];
          out_data    <= w_data0;
          out_last    <= ({1'b0, r_ptr} == c_last);
          r_buf_index <= w_ptr_p1[4:0];
          r_buf_data  <= rd_data2;
          r_buf_last  <= (w_ptr_p1 == c_last);
          if (w_pair) begin
            r_count <= 2'd2;
            r_ptr   <= r_ptr + 6'd2;
          end else begin
            r_count <= 2'd1;
            r_ptr   <= r_ptr + 6'd1;
          end
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_beat) begin
            if (r_count == 2'd2) begin
              r_count   <= 2'd1;
              out_index <= r_buf_index;
              out_data  <= r_buf_data;
              out_last  <= r_buf_last;
            end else begin
              r_count   <= 2'd0;
              out_valid <= 1'b0;
              if ({1'b0, r_ptr} > c_last) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_state <= S_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_ptr   <= c_first;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_dump_reader: table-driven bench for regfile_dump_reader.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  out_ready;
  wire  [2:0]  busy;
  wire  [2:0]  done;
  wire  [2:0]  out_valid;
  wire  [2:0]  out_last;
  wire  [4:0]  rd_addr1 [3];
  wire  [4:0]  rd_addr2 [3];
  wire  [31:0] rd_data1 [3];
  wire  [31:0] rd_data2 [3];
  wire  [4:0]  out_index [3];
  wire  [31:0] out_data [3];

  logic [31:0] regs [32];
  int          checks;
  int          failures;

  typedef struct {
    int         sel;
    logic [3:0] pat;
    int         first;
    int         last;
    bit         poke;
  } vec_t;

  vec_t vecs [6];

  // Three instances cover the full range, a sub-range and a single register.
  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .ZERO_X0(1'b1)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .rd_addr1(rd_addr1[0]), .rd_addr2(rd_addr2[0]), .rd_data1(rd_data1[0]), .rd_data2(rd_data2[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_index(out_index[0]),
    .out_data(out_data[0]), .out_last(out_last[0])
  );
  regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(9), .ZERO_X0(1'b1)) u_rng (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .rd_addr1(rd_addr1[1]), .rd_addr2(rd_addr2[1]), .rd_data1(rd_data1[1]), .rd_data2(rd_data2[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_index(out_index[1]),
    .out_data(out_data[1]), .out_last(out_last[1])
  );
  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(0), .ZERO_X0(1'b1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .rd_addr1(rd_addr1[2]), .rd_addr2(rd_addr2[2]), .rd_data1(rd_data1[2]), .rd_data2(rd_data2[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_index(out_index[2]),
    .out_data(out_data[2]), .out_last(out_last[2])
  );

  for (genvar k = 0; k < 3; k++) begin : g_rf
    assign rd_data1[k] = regs[rd_addr1[k]];
    assign rd_data2[k] = regs[rd_addr2[k]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_data(input int idx);
    return (idx == 0) ? 32'h0 : 32'(idx) * 32'h01010101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_dump(input int sel, input logic [3:0] pat, input int first,
                          input int last, input bit poke);
    int          exp_idx;
    int          first_valid;
    int          last_beat;
    int          n;
    int          exp_done;
    bit          got_done;
    bit          pv;
    bit          pr;
    logic [4:0]  pi;
    logic [31:0] pd;
    logic        pl;
    n           = last - first + 1;
    exp_done    = (n / 2) * 3 + (n % 2) * 2 + 1;
    exp_idx     = first;
    first_valid = -1;
    last_beat   = -1;
    got_done    = 1'b0;
    pv = 1'b0; pr = 1'b0; pi = '0; pd = '0; pl = 1'b0;
    @(negedge clk);
    start[sel]     = 1'b1;
    out_ready[sel] = pat[0];
    for (int c = 1; c <= 300 && !got_done; c++) begin
      @(negedge clk);
      start[sel] = poke && (c == 5);
      if (c == 1) chk("busy_rise", 32'(busy[sel]), 32'd1);
      if (pv && !pr) begin
        chk("hold_valid", 32'(out_valid[sel]), 32'd1);
        chk("hold_index", 32'(out_index[sel]), 32'(pi));
        chk("hold_data", out_data[sel], pd);
        chk("hold_last", 32'(out_last[sel]), 32'(pl));
      end
      if (busy[sel] && !out_valid[sel]) begin
        chk("rd_addr1", 32'(rd_addr1[sel]), 32'(exp_idx));
        chk("rd_addr2", 32'(rd_addr2[sel]), (exp_idx + 1 <= last) ? 32'(exp_idx + 1) : 32'(exp_idx));
      end
      out_ready[sel] = pat[c % 4];
      if (out_valid[sel] && first_valid < 0) first_valid = c;
      if (out_valid[sel] && out_ready[sel]) begin
        chk("beat_index", 32'(out_index[sel]), 32'(exp_idx));
        chk("beat_data", out_data[sel], exp_data(exp_idx));
        chk("beat_last", 32'(out_last[sel]), 32'(exp_idx == last));
        last_beat = c;
        exp_idx++;
      end
      if (done[sel]) begin
        got_done = 1'b1;
        chk("done_busy", 32'(busy[sel]), 32'd0);
        chk("beat_count", 32'(exp_idx), 32'(last + 1));
        chk("done_after_last", 32'(c), 32'(last_beat + 1));
        chk("first_valid", 32'(first_valid), 32'd2);
        if (pat == 4'hF) chk("done_cycle", 32'(c), 32'(exp_done));
      end
      pv = out_valid[sel]; pr = out_ready[sel];
      pi = out_index[sel]; pd = out_data[sel]; pl = out_last[sel];
    end
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    if (poke) begin
      // A start held during the DONE cycle must not launch a second dump.
      start[sel] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        start[sel] = 1'b0;
        chk("poke_idle_busy", 32'(busy[sel]), 32'd0);
        chk("poke_idle_valid", 32'(out_valid[sel]), 32'd0);
        chk("poke_idle_done", 32'(done[sel]), 32'd0);
      end
    end
  endtask

  initial begin
    bit seen12;
    checks    = 0;
    failures  = 0;
    start     = '0;
    out_ready = '0;
    regs[0]   = 32'hDEADBEEF;
    for (int i = 1; i < 32; i++) regs[i] = 32'(i) * 32'h01010101;

    // Vectors 0 -> 1 also exercise a start the cycle right after done.
    vecs[0] = '{sel: 0, pat: 4'b1111, first: 0, last: 31, poke: 1'b0};
    vecs[1] = '{sel: 0, pat: 4'b1001, first: 0, last: 31, poke: 1'b0};
    vecs[2] = '{sel: 1, pat: 4'b1111, first: 5, last: 9,  poke: 1'b0};
    vecs[3] = '{sel: 1, pat: 4'b0110, first: 5, last: 9,  poke: 1'b0};
    vecs[4] = '{sel: 2, pat: 4'b1111, first: 0, last: 0,  poke: 1'b0};
    vecs[5] = '{sel: 0, pat: 4'b1111, first: 0, last: 31, poke: 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
      chk("rst_done", 32'(done[k]), 32'd0);
      chk("rst_last", 32'(out_last[k]), 32'd0);
      chk("rst_index", 32'(out_index[k]), 32'd0);
      chk("rst_data", out_data[k], 32'd0);
    end

    for (int v = 0; v < 6; v++)
      run_dump(vecs[v].sel, vecs[v].pat, vecs[v].first, vecs[v].last, vecs[v].poke);

    // Reset in the middle of a dump, right after index 12 is accepted.
    @(negedge clk);
    start[0]     = 1'b1;
    out_ready[0] = 1'b1;
    seen12       = 1'b0;
    for (int c = 0; c < 100 && !seen12; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (out_valid[0] && out_index[0] == 5'd12) seen12 = 1'b1;
    end
    chk("reach_index12", 32'(seen12), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid[0]), 32'd0);
    chk("async_busy", 32'(busy[0]), 32'd0);
    chk("async_index", 32'(out_index[0]), 32'd0);
    chk("async_data", out_data[0], 32'd0);
    chk("async_last", 32'(out_last[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done[0]), 32'd0);
      chk("post_rst_valid", 32'(out_valid[0]), 32'd0);
      chk("post_rst_busy", 32'(busy[0]), 32'd0);
    end
    run_dump(0, 4'b1111, 0, 31, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader that walks a contiguous range of the 32x32 register file and streams each register out over a valid/ready interface.
- Drives the register file's two combinational read ports and fetches two registers per access.
- Sits beside the datapath as a debug/trace engine; the processor is stalled while a dump runs.

Parameters:
- FIRST_REG, 0: first register index dumped (0..31).
- LAST_REG, 31: last register index dumped (FIRST_REG..31).
- ZERO_X0, 1: when 1, index 0 is emitted as 32'h0 regardless of rd_data (x0 is never written and would read X).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; ignored unless idle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last beat is accepted.
- rd_addr1  output  5  register file read address, port 1.
- rd_addr2  output  5  register file read address, port 2.
- rd_data1  input  32  register file read data, port 1 (combinational from rd_addr1).
- rd_data2  input  32  register file read data, port 2.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_index  output  5  register index of the current beat.
- out_data  output  32  register value of the current beat.
- out_last  output  1  high on the beat for LAST_REG.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy, done, out_valid, out_last = 0; out_index, out_data = 0.
  - Pointer = FIRST_REG; buffer emptied.
- Pointer is 6 bits internally, so advancing past 31 never wraps to 0.
- rd_addr1 = ptr[4:0]. rd_addr2 = ptr+1 when ptr+1 <= LAST_REG, else ptr[4:0].
- Address outputs are valid in every state. They are only sampled in FETCH.
- IDLE:
  - start=1 -> FETCH, busy=1 next cycle.
  - start is ignored in every other state.
- FETCH (exactly 1 cycle):
  - Capture rd_data1 into buffer entry 0 (index ptr).
  - If ptr+1 <= LAST_REG, also capture rd_data2 into entry 1 (index ptr+1), set count=2, ptr += 2.
  - Otherwise set count=1, ptr += 1.
  - Go to DRAIN.
- DRAIN:
  - out_valid=1 while count>0. The beat presents entry 0 first, then entry 1.
  - Beat transfers on the rising edge with out_valid && out_ready.
  - out_index, out_data, out_last are held stable while out_valid=1 and out_ready=0.
  - When the final buffered beat transfers:
    - If ptr > LAST_REG -> DONE.
    - Otherwise -> FETCH. out_valid is 0 during FETCH.
- DONE (1 cycle): done=1, busy=0 (busy drops in this cycle), ptr reloads FIRST_REG, then -> IDLE.
  - A start in the DONE cycle is ignored.
- ZERO_X0=1: a captured index 0 stores 32'h0 instead of rd_data.
- out_last=1 only on the beat whose out_index == LAST_REG.
- Latency:
  - start sampled at edge 0; FETCH during cycle 1; first out_valid in cycle 2.
  - With out_ready held at 1: 3 cycles per pair and 2 cycles for a trailing single.
  - Full dump 0..31: 48 cycles from FETCH entry to the last beat; done asserts on the following cycle.
- Coherency:
  - The register file writes on the falling edge; values are sampled at the FETCH rising edge.
  - The dump is coherent only if no write occurs during busy. The system stalls writeback; the block does not check this.
- Reset mid-dump: all state is cleared immediately. No done pulse, no further beats. A later start restarts from FIRST_REG.
- FIRST_REG == LAST_REG: one FETCH with count=1, one beat with out_last=1, then done.

Test Plan:
- Preload reg[i]=i*32'h01010101 for i=1..31; start with out_ready=1 -> 32 beats, index 0..31.
  - Beat 0 data 0 (ZERO_X0), beat 31 data 32'h1F1F1F1F with out_last=1.
  - done exactly 1 cycle after the last beat; first out_valid 2 cycles after start.
- Same preload; out_ready toggles 1,0,0,1... -> identical beat sequence.
  - out_data and out_index stable whenever valid && !ready; no beat dropped or duplicated.
- FIRST_REG=5, LAST_REG=9 -> pairs (5,6),(7,8), then single 9.
  - rd_addr2=9 when ptr=9; 5 beats; out_last only on index 9.
- Mid-dump (after the beat for index 12) pulse rst_n low for 1 cycle -> outputs 0 asynchronously, no done.
  - A new start yields the full sequence from index 0.
- Pulse start while busy and in the DONE cycle -> ignored: single sequence, single done.
- Pulse start 1 cycle after done -> a second complete dump.
- FIRST_REG=LAST_REG=0, ZERO_X0=1, rd_data1=32'hDEADBEEF -> one beat: index 0, data 0, out_last=1, then done.
